// File: rtl/seg_scan_drv_if.sv
// seg_scan_drv_if: load handshake and scan outputs of the seven-segment display driver
interface seg_scan_drv_if;
    logic [13:0] BIN;
    logic        LOAD;
    logic        BUSY;
    logic [3:0]  BCD;
    logic [1:0]  SEL;
    logic        OVF;

    modport master (output BIN, LOAD, input BUSY, BCD, SEL, OVF);
    modport slave  (input BIN, LOAD, output BUSY, BCD, SEL, OVF);
endinterface

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: double-dabble binary-to-BCD converter plus 4-digit display scanner.
// Optional macro SEG_SCAN_SAT_EN: saturate display to 9999 and raise OVF above 9999.
module seg_scan_drv #(
    parameter int SCAN_DIV = 50000
) (
    input  logic          CLK,
    input  logic          RST_N,
    seg_scan_drv_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [13:0]     sr_q, sr_d;
    logic [19:0]     acc_q, acc_d, adj;
    logic [3:0]      it_q, it_d;
    logic [15:0]     disp_q, disp_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   scan_q, scan_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      bcd_q, bcd_d;
    logic            tc;

    // Add-3 correction of every accumulator nibble that is 5 or more
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 5; i++)
            adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end

    // Conversion FSM: capture on LOAD, 14 shift iterations, then one-edge commit of all digits
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        it_d    = it_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.LOAD) begin
                    sr_d    = bus.BIN;
                    acc_d   = '0;
                    it_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, sr_d} = {adj[18:0], sr_q, 1'b0};
                it_d          = it_q + 4'd1;
                state_d       = (it_q == 4'd13) ? COMMIT : SHIFT;
            end
            COMMIT: begin
`ifdef SEG_SCAN_SAT_EN
                ovf_d  = acc_q[19:16] != 4'd0;
                disp_d = ovf_d ? 16'h9999 : acc_q[15:0];
`else
                ovf_d  = 1'b0;
                disp_d = acc_q[15:0];
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scanner; BCD follows the select value it will hold after this edge
    always_comb begin
        tc     = scan_q == CW'(SCAN_DIV - 1);
        scan_d = tc ? '0 : scan_q + 1'b1;
        sel_d  = tc ? sel_q + 2'd1 : sel_q;
        bcd_d  = disp_q[{sel_d, 2'b00} +: 4];
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            it_q    <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
            sel_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            it_q    <= it_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.BUSY = state_q != IDLE;
    assign bus.BCD  = bcd_q;
    assign bus.SEL  = sel_q;
    assign bus.OVF  = ovf_q;
endmodule

// File: doc/seg_scan_drv.md
# seg_scan_drv

Sequential front end for the 4-digit multiplexed seven-segment display on the smart car board. It accepts a 14-bit binary value on a load handshake and converts it to four BCD digits with an iterative shift-add-3 (double dabble) engine. It then time-multiplexes the digits, emitting one 4-bit BCD code plus a 2-bit digit select per scan slot. Its `BCD`/`SEL` outputs drive the existing BCD-to-segment decoder's `BCD`/`SEL_IN` inputs directly.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥ 2.

Ports:
- `CLK`  input  1  system clock, all logic on rising edge.
- `RST_N`  input  1  reset; one clock, reset is synchronous and active-low.
- `BIN`  input  14  unsigned binary value to display, sampled on accepted `LOAD`.
- `LOAD`  input  1  load request, single-cycle pulse or level; accepted only when `BUSY`=0.
- `BUSY`  output  1  conversion in progress; new `LOAD` ignored while high.
- `BCD`  output  4  BCD code of the digit currently selected.
- `SEL`  output  2  digit select: 0 = units, 1 = tens, 2 = hundreds, 3 = thousands.
- `OVF`  output  1  last loaded value exceeded 9999 (only with macro; see Configuration).

## Operation

- Reset (`RST_N`=0 at an edge): `BUSY`=0, `OVF`=0, `SEL`=0, `BCD`=0, scan counter=0, all four display digits=0, conversion state cleared. Reset overrides everything, including a conversion in flight.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: if `LOAD`=1, capture `BIN` into an 14-bit shift register and clear a 20-bit BCD accumulator (5 digits), set iteration count 0, go SHIFT, `BUSY`←1. Otherwise stay.
  - SHIFT: each cycle, add 3 to every accumulator nibble ≥ 5, then shift {accumulator, shift reg} left 1. After the 14th iteration, go COMMIT.
  - COMMIT: write the low four BCD nibbles into the display register (all four digits in one edge; never partially updated), update `OVF`, `BUSY`←0, go IDLE.
- `LOAD` in SHIFT/COMMIT is dropped, not queued.
- Scanner runs continuously and independently of the FSM: counter 0..`SCAN_DIV`-1. At terminal count, counter wraps to 0 and `SEL` increments, 3→0 wrap.
- `BCD` is registered: each edge `BCD` ← digit[`SEL` value after this edge]. `BCD` and `SEL` therefore always change on the same edge and are consistent.
- A display-register update mid-slot takes effect on `BCD` one edge after COMMIT, without disturbing `SEL` or the scan counter.

## Timing

- `LOAD` accepted at edge k: `BUSY`=1 after edge k. Iterations run at edges k+1..k+14. COMMIT occurs at edge k+15: `BUSY`=0 and the new digits are in the register after k+15.
- `BUSY` is high for exactly 15 cycles per conversion.
- `BCD` shows a new digit value after edge k+16.
- A new `LOAD` is accepted at the earliest at edge k+15's following edge (k+16), i.e. the first edge with `BUSY`=0.
- Digit slot length is exactly `SEL`-stable for `SCAN_DIV` cycles; full frame is 4·`SCAN_DIV` cycles.
- Reset asserted mid-conversion: the next edge forces IDLE state. The display keeps reset values, and no COMMIT happens for the aborted load.

## Configuration

- Macro `SEG_SCAN_SAT_EN`.
- Defined: when the converted value is > 9999 (ten-thousands nibble ≠ 0), all four display digits are written as 9 and `OVF`←1. A later in-range COMMIT clears `OVF`. `OVF` holds between commits.
- Not defined: the ten-thousands nibble is discarded, so the display shows `BIN` mod 10000. `OVF` is tied to 0.

## Test plan

Run the bench with `SCAN_DIV`=4.

- Reset: hold `RST_N`=0 for 3 cycles with `LOAD`=1, `BIN`=1234 → `BUSY`=0, `OVF`=0, `SEL`=0, `BCD`=0 after release; display reads 0000.
- Basic: pulse `LOAD` with `BIN`=1234 → `BUSY` high for exactly 15 cycles. Then over one frame, `SEL`=0,1,2,3 shows `BCD`=4,3,2,1, each held 4 cycles.
- Busy drop: `LOAD` `BIN`=42, then `LOAD` `BIN`=77 at cycle 5 of `BUSY` → display 0,0,4,2 (thousands to units). A third `LOAD` of 77 after `BUSY` falls → display 0077.
- Overflow: `LOAD` `BIN`=12345 → with `SEG_SCAN_SAT_EN`, digits are 9999 and `OVF`=1; then `LOAD` 5 → `OVF`=0. Without the macro, digits are 2345 and `OVF`=0.
- Abort: `LOAD` 8888, assert `RST_N`=0 at cycle 7 of `BUSY` → `BUSY`=0 next edge; digits stay 0000 and no late COMMIT occurs.
- Scan wrap: free-run 40 cycles after reset → `SEL` advances every 4 cycles, 3→0 wrap. The `BCD`/`SEL` change edges always coincide.
